// File: rtl/lfsr_prbs_check.sv
// rtl/lfsr_prbs_check.sv - self-synchronising PRBS checker with lock FSM and saturating error counter
module lfsr_prbs_check #(
    parameter int                    LFSR_WIDTH   = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
    parameter bit                    LFSR_INVERT  = 1'b1,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    LOCK_COUNT   = 4,
    parameter int                    UNLOCK_COUNT = 4,
    parameter int                    COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_valid,
    input  logic                   clear,
    output logic                   locked,
    output logic [DATA_WIDTH-1:0]  error_out,
    output logic                   error_valid,
    output logic [COUNT_WIDTH-1:0] error_count,
    output logic                   count_sat
);

    localparam int W          = LFSR_WIDTH;
    localparam int D          = DATA_WIDTH;
    localparam int POP_W      = $clog2(D + 1);
    localparam int SUM_W      = COUNT_WIDTH + POP_W;
    localparam int SEQ_W      = 16;
    localparam int FILL_WORDS = (W + D - 1) / D;

    // The x^0 term is implicit in the polynomial convention, so force it on.
    localparam logic [W-1:0]           TAPS      = LFSR_POLY | {{(W-1){1'b0}}, 1'b1};
    localparam logic [SEQ_W-1:0]       FILL_N    = SEQ_W'(FILL_WORDS);
    localparam logic [SEQ_W-1:0]       LOCK_N    = SEQ_W'(LOCK_COUNT);
    localparam logic [SEQ_W-1:0]       UNLOCK_N  = SEQ_W'(UNLOCK_COUNT);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_HUNT,
        ST_LOCKED
    } state_t;

    state_t                 state_q, state_d;
    logic [SEQ_W-1:0]       seq_q, seq_d, seq_inc;
    logic [W-1:0]           hist_q, hist_d;
    logic [D-1:0]           rx_bits, pred, err_mask;
    logic [W+D-1:0]         ext;
    logic [POP_W-1:0]       err_pop;
    logic                   word_err;
    logic [SUM_W-1:0]       sum;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   sat_d;

    // Predict every bit of the word from the history plus the earlier bits of the same word.
    // ext[0] is the oldest history bit, ext[W+i] is received bit i of this word.
    always_comb begin
        rx_bits = data_in ^ {D{LFSR_INVERT}};
        ext     = {rx_bits, hist_q};
        pred    = '0;
        for (int i = 0; i < D; i++) begin
            for (int k = 0; k < W; k++) begin
                if (TAPS[k]) begin
                    pred[i] = pred[i] ^ ext[i+k];
                end
            end
        end
        err_mask = rx_bits ^ pred;
        hist_d   = ext[W+D-1 -: W];
        word_err = |err_mask;
        err_pop  = '0;
        for (int i = 0; i < D; i++) begin
            err_pop = err_pop + POP_W'(err_mask[i]);
        end
    end

    // Lock FSM next state: one run counter shared by all states, cleared on every transition.
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        seq_inc = seq_q + 1'b1;
        if (data_valid) begin
            case (state_q)
                ST_FILL: begin
                    if (seq_inc == FILL_N) begin
                        state_d = ST_HUNT;
                        seq_d   = '0;
                    end else begin
                        seq_d = seq_inc;
                    end
                end
                ST_HUNT: begin
                    if (word_err) begin
                        seq_d = '0;
                    end else if (seq_inc == LOCK_N) begin
                        state_d = ST_LOCKED;
                        seq_d   = '0;
                    end else begin
                        seq_d = seq_inc;
                    end
                end
                ST_LOCKED: begin
                    if (!word_err) begin
                        seq_d = '0;
                    end else if (seq_inc == UNLOCK_N) begin
                        state_d = ST_HUNT;
                        seq_d   = '0;
                    end else begin
                        seq_d = seq_inc;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    seq_d   = '0;
                end
            endcase
        end
    end

    // Saturating error accumulator; clear takes priority over a same-cycle increment.
    always_comb begin
        count_d = error_count;
        sat_d   = count_sat;
        sum     = {{POP_W{1'b0}}, error_count} + {{COUNT_WIDTH{1'b0}}, err_pop};
        if (clear) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (data_valid && (state_q == ST_LOCKED)) begin
            if (sum >= {{POP_W{1'b0}}, COUNT_MAX}) begin
                count_d = COUNT_MAX;
            end else begin
                count_d = sum[COUNT_WIDTH-1:0];
            end
            if (count_d == COUNT_MAX) begin
                sat_d = 1'b1;
            end
        end
    end

    // FSM state, run counter and received-bit history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            seq_q   <= '0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            if (data_valid) begin
                hist_q <= hist_d;
            end
        end
    end

    // Registered per-word error report and error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_out   <= '0;
            error_valid <= 1'b0;
            error_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            error_valid <= data_valid && (state_q != ST_FILL);
            if (data_valid) begin
                error_out <= err_mask;
            end
            error_count <= count_d;
            count_sat   <= sat_d;
        end
    end

    assign locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_lfsr_prbs_check.sv
// tb/tb_lfsr_prbs_check.sv - self-checking bench for lfsr_prbs_check (PRBS9 D=8 and PRBS31 D=32 instances)
module tb_lfsr_prbs_check;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: PRBS9, D=8, non-inverted, 4-bit counter
    logic [7:0]  a_data;
    logic        a_valid, a_clear, a_locked, a_ev, a_sat;
    logic [7:0]  a_eout;
    logic [3:0]  a_cnt;

    // Instance B: PRBS31, D=32, inverted, 16-bit counter
    logic [31:0] b_data;
    logic        b_valid, b_clear, b_locked, b_ev, b_sat;
    logic [31:0] b_eout;
    logic [15:0] b_cnt;

    lfsr_prbs_check #(
        .LFSR_WIDTH(9), .LFSR_POLY(9'h021), .LFSR_INVERT(1'b0), .DATA_WIDTH(8),
        .LOCK_COUNT(4), .UNLOCK_COUNT(4), .COUNT_WIDTH(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(a_data), .data_valid(a_valid), .clear(a_clear),
        .locked(a_locked), .error_out(a_eout), .error_valid(a_ev),
        .error_count(a_cnt), .count_sat(a_sat)
    );

    lfsr_prbs_check #(
        .LFSR_WIDTH(31), .LFSR_POLY(31'h10000001), .LFSR_INVERT(1'b1), .DATA_WIDTH(32),
        .LOCK_COUNT(4), .UNLOCK_COUNT(4), .COUNT_WIDTH(16)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(b_data), .data_valid(b_valid), .clear(b_clear),
        .locked(b_locked), .error_out(b_eout), .error_valid(b_ev),
        .error_count(b_cnt), .count_sat(b_sat)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit sel     = 1'b0;

    // Reference model configuration and state
    int          m_w, m_d, m_cw;
    bit          m_inv;
    logic [30:0] m_poly;
    bit          rxq[$];
    bit          gq[$];
    int          m_phase;
    int          m_run;
    int          m_cnt;
    bit          m_sat;
    bit          m_ev;
    logic [31:0] m_eout;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void cfg(input int w, input logic [30:0] poly, input bit inv, input int d, input int cw);
        m_w = w; m_poly = poly; m_inv = inv; m_d = d; m_cw = cw;
    endfunction

    function automatic void model_reset();
        rxq = {};
        for (int i = 0; i < m_w; i++) rxq.push_back(1'b0);
        m_phase = 0; m_run = 0; m_cnt = 0; m_sat = 0; m_ev = 0; m_eout = '0;
    endfunction

    function automatic void gen_seed();
        gq = {};
        for (int i = 0; i < m_w; i++) gq.push_back(1'b1);
    endfunction

    // Next word of the transmitted PRBS: b_n = XOR of b_{n-W+k} over taps (x^0 always), wire = b ^ invert.
    function automatic logic [31:0] gen_word();
        logic [31:0] raw = '0;
        for (int i = 0; i < m_d; i++) begin
            bit nb = 1'b0;
            for (int k = 0; k < m_w; k++)
                if (k == 0 || m_poly[k]) nb ^= gq[k];
            gq.push_back(nb);
            void'(gq.pop_front());
            raw[i] = nb ^ m_inv;
        end
        return raw;
    endfunction

    // Behavioural checker model: one call per clock cycle with that cycle's inputs.
    function automatic void model_cycle(input bit valid, input logic [31:0] raw, input bit clr);
        int          pop = 0;
        int          was = m_phase;
        int          maxv = (1 << m_cw) - 1;
        logic [31:0] mask = '0;
        if (valid) begin
            for (int i = 0; i < m_d; i++) begin
                bit b = raw[i] ^ m_inv;
                bit p = 1'b0;
                for (int k = 0; k < m_w; k++)
                    if (k == 0 || m_poly[k]) p ^= rxq[k];
                mask[i] = b ^ p;
                pop += int'(mask[i]);
                rxq.push_back(b);
                void'(rxq.pop_front());
            end
        end
        if (clr) begin
            m_cnt = 0; m_sat = 0;
        end else if (valid && was == 2) begin
            m_cnt = (m_cnt + pop > maxv) ? maxv : m_cnt + pop;
            if (m_cnt == maxv) m_sat = 1;
        end
        m_ev = valid && (was != 0);
        if (valid) begin
            m_eout = mask;
            if (was == 0) begin
                m_run++;
                if (m_run == (m_w + m_d - 1) / m_d) begin m_phase = 1; m_run = 0; end
            end else if (was == 1) begin
                if (pop != 0) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == 4) begin m_phase = 2; m_run = 0; end
                end
            end else begin
                if (pop == 0) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == 4) begin m_phase = 1; m_run = 0; end
                end
            end
        end
    endfunction

    task automatic compare_all(input string tag);
        if (sel == 1'b0) begin
            chk({tag, " locked"},      a_locked, m_phase == 2);
            chk({tag, " error_valid"}, a_ev,     m_ev);
            chk({tag, " error_out"},   a_eout,   m_eout[7:0]);
            chk({tag, " error_count"}, a_cnt,    m_cnt);
            chk({tag, " count_sat"},   a_sat,    m_sat);
        end else begin
            chk({tag, " locked"},      b_locked, m_phase == 2);
            chk({tag, " error_valid"}, b_ev,     m_ev);
            chk({tag, " error_out"},   b_eout,   m_eout);
            chk({tag, " error_count"}, b_cnt,    m_cnt);
            chk({tag, " count_sat"},   b_sat,    m_sat);
        end
    endtask

    task automatic step(input bit valid, input logic [31:0] raw, input bit clr);
        @(negedge clk);
        if (sel == 1'b0) begin
            a_valid = valid; a_data = raw[7:0]; a_clear = clr;
        end else begin
            b_valid = valid; b_data = raw; b_clear = clr;
        end
        model_cycle(valid, raw, clr);
        @(posedge clk);
        #1;
        compare_all("model");
    endtask

    task automatic send(input logic [31:0] inj, input bit clr);
        logic [31:0] w = gen_word();
        step(1'b1, w ^ inj, clr);
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        a_valid = 0; a_clear = 0; b_valid = 0; b_clear = 0;
    endtask

    typedef struct {
        int         words;
        logic [7:0] inj;
        bit         clr;
        bit         exp_locked;
        bit         exp_ev;
        int         exp_cnt;
        bit         exp_sat;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] stream[60];
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int cnt0;
        int relock;
        rst_n = 0;
        a_valid = 0; a_data = 0; a_clear = 0;
        b_valid = 0; b_data = 0; b_clear = 0;

        // ---------------- Instance A: PRBS9 D=8 ----------------
        sel = 0;
        cfg(9, 31'h021, 1'b0, 8, 4);
        model_reset();
        gen_seed();
        repeat (3) @(posedge clk);
        #1;
        chk("reset locked", a_locked, 0);
        chk("reset error_valid", a_ev, 0);
        chk("reset error_out", a_eout, 0);
        chk("reset error_count", a_cnt, 0);
        chk("reset count_sat", a_sat, 0);
        @(negedge clk) rst_n = 1;

        // words, inject, clear, locked, error_valid, error_count, count_sat
        // A flipped wire bit is flagged itself plus once per feedback tap (bit0 -> bits 0,4 and next word bit 1).
        tbl.push_back('{1,    8'h00, 0, 0, 0, 0, 0});
        tbl.push_back('{1,    8'h00, 0, 0, 0, 0, 0});
        tbl.push_back('{1,    8'h00, 0, 0, 1, 0, 0});
        tbl.push_back('{2,    8'h00, 0, 0, 1, 0, 0});
        tbl.push_back('{1,    8'h00, 0, 1, 1, 0, 0});
        tbl.push_back('{1000, 8'h00, 0, 1, 1, 0, 0});
        tbl.push_back('{1,    8'h01, 0, 1, 1, 2, 0});
        tbl.push_back('{1,    8'h00, 0, 1, 1, 3, 0});
        tbl.push_back('{3,    8'h00, 0, 1, 1, 3, 0});
        tbl.push_back('{1,    8'h00, 1, 1, 1, 0, 0});
        foreach (tbl[r]) begin
            for (int n = 0; n < tbl[r].words; n++) send({24'h0, tbl[r].inj}, tbl[r].clr);
            chk($sformatf("row%0d locked", r),      a_locked, tbl[r].exp_locked);
            chk($sformatf("row%0d error_valid", r), a_ev,     tbl[r].exp_ev);
            chk($sformatf("row%0d error_count", r), a_cnt,    tbl[r].exp_cnt);
            chk($sformatf("row%0d count_sat", r),   a_sat,    tbl[r].exp_sat);
        end

        // 20 isolated single-bit errors saturate the 4-bit counter
        for (int e = 0; e < 20; e++) begin
            send(32'h01, 0);
            repeat (3) send(32'h0, 0);
        end
        chk("sat error_count", a_cnt, 15);
        chk("sat count_sat", a_sat, 1);
        chk("sat locked", a_locked, 1);
        send(32'h01, 1);
        chk("clear_wins error_count", a_cnt, 0);
        chk("clear_wins count_sat", a_sat, 0);
        send(32'h0, 0);
        chk("after_clear echo count", a_cnt, 1);

        // Randomised traffic: gaps, sparse errors, bursts that force unlock, occasional clear
        for (int c = 0; c < 800; c++) begin
            bit          v   = ($urandom % 4) != 0;
            bit          clr = ($urandom % 64) == 0;
            logic [31:0] inj = '0;
            if ((c % 150) >= 140) inj = {24'h0, 8'($urandom)};
            else if (($urandom % 16) == 0) inj = 32'h1 << ($urandom % 8);
            if (v) send(inj, clr);
            else step(1'b0, $urandom, clr);
        end

        // ---------------- Instance B: PRBS31 D=32 inverted ----------------
        idle_inputs();
        sel = 1;
        rst_n = 0;
        cfg(31, 31'h10000001, 1'b1, 32, 16);
        model_reset();
        gen_seed();
        @(negedge clk) rst_n = 1;

        for (int i = 0; i < 60; i++) begin
            stream[i] = gen_word();
            if (i == 20 || i == 40) stream[i] ^= 32'h8;
        end
        for (int i = 0; i < 60; i++) begin
            step(1'b1, stream[i], 0);
            if (b_ev) q1.push_back(b_eout);
        end

        idle_inputs();
        rst_n = 0;
        model_reset();
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 60; i++) begin
            while (($urandom % 2) == 0) begin
                step(1'b0, $urandom, 0);
                chk("gap error_valid low", b_ev, 0);
            end
            step(1'b1, stream[i], 0);
            if (b_ev) q2.push_back(b_eout);
        end
        chk("gap report count", q2.size(), q1.size());
        chk("gap-free report count", q1.size(), 59);
        for (int i = 0; i < q1.size() && i < q2.size(); i++)
            chk($sformatf("gap error_out[%0d]", i), q2[i], q1[i]);

        // Four all-zero words while locked drop lock
        repeat (8) send(32'h0, 0);
        chk("pre_zero locked", b_locked, 1);
        cnt0 = int'(b_cnt);
        for (int z = 0; z < 4; z++) begin
            step(1'b1, 32'h0, 0);
            chk($sformatf("zero%0d locked", z), b_locked, z < 3);
        end
        chk("zero run counted", (int'(b_cnt) - cnt0) >= 97, 1);
        relock = 0;
        while (!b_locked && relock < 12) begin
            send(32'h0, 0);
            relock++;
        end
        chk("relock words", (relock >= 4) && (relock <= 5), 1);

        // Asynchronous reset mid-stream, then relock after 1 fill + 4 clean words
        repeat (3) send(32'h0, 0);
        @(negedge clk);
        b_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("async locked", b_locked, 0);
        chk("async error_valid", b_ev, 0);
        chk("async error_out", b_eout, 0);
        chk("async error_count", b_cnt, 0);
        chk("async count_sat", b_sat, 0);
        model_reset();
        @(negedge clk) rst_n = 1;
        for (int i = 1; i <= 5; i++) begin
            send(32'h0, 0);
            chk($sformatf("post_reset word%0d locked", i), b_locked, i == 5);
        end

        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
